// File: rtl/pll_lock_cnt.sv
// Lock-qualified wrapping up/down counter: waits for a stable synchronised PLL lock, then counts.
// Latency: 2 cycles lock sync + LOCK_STABLE cycles qualification; cnt/tc update one edge after inputs.
// Backpressure: none; strobes are sampled every clk_div edge and ignored outside RUN.
module pll_lock_cnt #(
    parameter int CNT_W       = 2,
    parameter int CNT_MAX     = 3,
    parameter int LOCK_STABLE = 4
) (
    input  logic             clk_div,
    input  logic             sys_rst_n,
    input  logic             locked,
    input  logic             cnt_en,
    input  logic             cnt_dir,
    input  logic             cnt_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc,
    output logic             run,
    output logic             lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(CNT_MAX);
    localparam logic [7:0]       STAB_LAST = 8'(LOCK_STABLE - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [7:0]       r_stab;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tc;
    logic             r_run;
    logic             r_lock_lost;

    logic             w_locked_s;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tc_nxt;

    assign w_locked_s = r_sync2;

    // Two-flop synchroniser for the asynchronous PLL lock indicator.
    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    // Counter next value in RUN: clear beats load beats count; only a wrap raises tc.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_tc_nxt  = 1'b0;
        if (cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            w_cnt_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (cnt_en) begin
            if (!cnt_dir) begin
                if (r_cnt >= MAX_V) begin
                    w_cnt_nxt = '0;
                    w_tc_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = MAX_V;
                    w_tc_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Lock-qualification FSM with registered counter, tc, run and sticky lock_lost.
    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= WAIT_LOCK;
            r_stab      <= 8'd0;
            r_cnt       <= '0;
            r_tc        <= 1'b0;
            r_run       <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            // flag_clr only acts when no new loss is reported on the same edge.
            if (flag_clr) begin
                r_lock_lost <= 1'b0;
            end
            case (r_state)
                WAIT_LOCK: begin
                    r_cnt <= '0;
                    r_run <= 1'b0;
                    if (w_locked_s) begin
                        r_state <= STABILIZE;
                        r_stab  <= 8'd0;
                    end
                end
                STABILIZE: begin
                    r_cnt <= '0;
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_run   <= 1'b0;
                    end else if (r_stab == STAB_LAST) begin
                        r_state <= RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 8'd1;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        r_state     <= WAIT_LOCK;
                        r_run       <= 1'b0;
                        r_cnt       <= '0;
                        r_lock_lost <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tc  <= w_tc_nxt;
                    end
                end
                default: begin
                    r_state <= WAIT_LOCK;
                    r_run   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cnt       = r_cnt;
    assign tc        = r_tc;
    assign run       = r_run;
    assign lock_lost = r_lock_lost;

endmodule

// File: doc/pll_lock_cnt.md
PLL_LOCK_CNT -- requirements
Module: pll_lock_cnt

Interface
REQ-001 The block SHALL have parameter CNT_W, default 2, giving the counter width in bits.
REQ-002 The block SHALL have parameter CNT_MAX, default 3, giving the terminal value; legal range 1 to 2^CNT_W-1.
REQ-003 The block SHALL have parameter LOCK_STABLE, default 4, giving the consecutive synchronised-locked cycles required before counting; legal range 1 to 255.
REQ-004 The block SHALL have port clk_div, input, 1 bit: the clock for all logic.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port locked, input, 1 bit: PLL lock indicator, asynchronous to clk_div.
REQ-007 The block SHALL have port cnt_en, input, 1 bit: count enable.
REQ-008 The block SHALL have port cnt_dir, input, 1 bit: 0 counts up, 1 counts down.
REQ-009 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear.
REQ-010 The block SHALL have ports load (input, 1 bit, load strobe) and load_val (input, CNT_W bits, value to load).
REQ-011 The block SHALL have port flag_clr, input, 1 bit: clears lock_lost.
REQ-012 The block SHALL have port cnt, output, CNT_W bits, registered: the counter value.
REQ-013 The block SHALL have port tc, output, 1 bit, registered: terminal-count pulse.
REQ-014 The block SHALL have port run, output, 1 bit, registered: high while in state RUN.
REQ-015 The block SHALL have port lock_lost, output, 1 bit, registered: sticky flag, set when lock drops during RUN.

Function
REQ-016 The block SHALL synchronise locked through two clk_div flops (locked_s); all decisions SHALL use locked_s only.
REQ-017 The FSM SHALL have exactly three states: WAIT_LOCK, STABILIZE and RUN.
REQ-018 WAIT_LOCK SHALL go to STABILIZE on the edge where locked_s=1, clearing the stability counter to 0.
REQ-019 In STABILIZE, while locked_s=1, the stability counter SHALL increment each cycle; on the edge where it reaches LOCK_STABLE-1 the FSM SHALL go to RUN.
REQ-020 In STABILIZE, locked_s=0 SHALL return the FSM to WAIT_LOCK; lock_lost SHALL NOT be set.
REQ-021 In RUN, locked_s=0 SHALL return the FSM to WAIT_LOCK on the next edge, set lock_lost=1, clear cnt to 0, and drop run.
REQ-022 Outside RUN, cnt SHALL hold 0 and tc SHALL be 0; cnt_en, cnt_clr and load SHALL be ignored.
REQ-023 In RUN, priority SHALL be cnt_clr (cnt<=0), then load, then cnt_en counting, then hold.
REQ-024 On load, cnt SHALL take load_val; if load_val > CNT_MAX, cnt SHALL take CNT_MAX.
REQ-025 Up counting with cnt_en=1 SHALL increment; at cnt==CNT_MAX the next value SHALL be 0 (wrap).
REQ-026 Down counting with cnt_en=1 SHALL decrement; at cnt==0 the next value SHALL be CNT_MAX (wrap).
REQ-027 tc SHALL be 1 for exactly the one cycle following a wrap edge, coincident with the wrapped cnt value; otherwise 0.
REQ-028 Clear and load SHALL never assert tc.
REQ-029 A cnt_dir change SHALL take effect on the same edge it is sampled.
REQ-030 lock_lost SHALL stay at 1 until flag_clr=1 is sampled.
REQ-031 If a set event and flag_clr coincide, set SHALL win.
REQ-032 run SHALL equal (state==RUN), registered with the state.

Reset
REQ-033 While sys_rst_n=0, the block SHALL hold: state=WAIT_LOCK, sync flops=0, stability counter=0, cnt=0, tc=0, run=0, lock_lost=0.
REQ-034 Reset release SHALL take effect on the first clk_div edge after deassertion; assertion mid-RUN SHALL force all reset values immediately.

Verification
REQ-035 Defaults, locked rises 1 then held high: run=1 after 2 sync + 4 stable cycles (±1 edge for asynchronous sampling); cnt=0 on entry.
REQ-036 CNT_W=4, CNT_MAX=9, up, cnt_en=1: cnt runs 0..9,0; tc=1 only in the cycle with cnt=0 after 9; period 10 cycles.
REQ-037 CNT_W=4, CNT_MAX=9, down from load_val=2: cnt runs 2,1,0,9; tc=1 with cnt=9; load_val=15 loads 9 with tc=0.
REQ-038 locked dropped for 1 cycle during STABILIZE -> FSM returns to WAIT_LOCK, lock_lost=0, full LOCK_STABLE wait again.
REQ-039 locked dropped in RUN with cnt=5 -> cnt=0, run=0, lock_lost=1; holds through relock; flag_clr clears it; flag_clr coincident with a new drop leaves it at 1.
REQ-040 cnt_clr, load and cnt_en all high in RUN -> cnt=0, tc=0; sys_rst_n pulsed low mid-count -> all outputs 0 immediately.
